// File: rtl/cv_frame_pkg.sv
// Shared types and default constants for the CV frame controller.
// Holds the FSM state enum and the clamp helper used by the capture path.
package cv_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        PUBLISH,
        RECOVER
    } cv_state_e;

    localparam int          CV_WORDS        = 6;
    localparam logic [15:0] CV_MAX_DEFAULT  = 16'h0FFF;
    localparam logic [23:0] TIMEOUT_DEFAULT = 24'd1_000_000;
    localparam int          RECOVER_DEFAULT = 8;

    function automatic logic [15:0] clampWord(input logic [15:0] word, input logic [15:0] limit);
        return (word > limit) ? limit : word;
    endfunction

endpackage

// File: rtl/cv_frame_sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// previous value so the output is a single-cycle pulse per rising edge.
module sync_rise_detect (
    input  logic clock_i,
    input  logic reset_i,
    input  logic level_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= level_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/cv_frame_controller.sv
// Turns the receiver's frame flag and six words into an atomic, clamped CV
// snapshot, and supervises the link with a watchdog that resets the receiver.
module cv_frame_controller
    import cv_frame_pkg::*;
#(
    parameter int          WORDS          = CV_WORDS,
    parameter logic [15:0] CV_MAX         = CV_MAX_DEFAULT,
    parameter int          SETTLE_CYCLES  = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int          RECOVER_CYCLES = RECOVER_DEFAULT
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Frame_Ready,
    input  logic [15:0] i_Data0,
    input  logic [15:0] i_Data1,
    input  logic [15:0] i_Data2,
    input  logic [15:0] i_Data3,
    input  logic [15:0] i_Data4,
    input  logic [15:0] i_Data5,
    output logic [15:0] o_CV0,
    output logic [15:0] o_CV1,
    output logic [15:0] o_CV2,
    output logic [15:0] o_CV3,
    output logic [15:0] o_CV4,
    output logic [15:0] o_CV5,
    output logic        o_Frame_Strobe,
    output logic [5:0]  o_Clamp_Flags,
    output logic        o_Link_OK,
    output logic        o_Receiver_Reset,
    output logic [7:0]  o_Frame_Count
);

    // The edge that enters SETTLE already counts as the first settle cycle.
    localparam int          SETTLE_LAST_INT = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;
    localparam logic [3:0]  SETTLE_LAST     = SETTLE_LAST_INT[3:0];
    localparam int          LAST_INDEX_INT  = WORDS - 1;
    localparam logic [2:0]  LAST_INDEX      = LAST_INDEX_INT[2:0];
    localparam logic [7:0]  RECOVER_LAST    = RECOVER_CYCLES[7:0];
    localparam logic [23:0] WD_LIMIT        = TIMEOUT_CYCLES - 24'd1;

    logic frameRise;

    sync_rise_detect uSyncRise (
        .clock_i (i_Clock),
        .reset_i (i_Reset),
        .level_i (i_Frame_Ready),
        .rise_o  (frameRise)
    );

    cv_state_e                     state_q, state_d;
    logic [3:0]                    settleCnt_q, settleCnt_d;
    logic [2:0]                    index_q, index_d;
    logic [7:0]                    recoverCnt_q, recoverCnt_d;
    logic [23:0]                   wdCount_q, wdCount_d;
    logic [CV_WORDS-1:0][15:0]     shadow_q, shadow_d;
    logic [CV_WORDS-1:0]           shadowFlags_q, shadowFlags_d;
    logic [CV_WORDS-1:0][15:0]     cv_q, cv_d;
    logic [5:0]                    clampFlags_q, clampFlags_d;
    logic                          strobe_q, strobe_d;
    logic                          linkOk_q, linkOk_d;
    logic                          rxReset_q, rxReset_d;
    logic [7:0]                    frameCount_q, frameCount_d;

    logic        wdExpired;
    logic        settleDone;
    logic        captureDone;
    logic        recoverDone;
    logic [15:0] selWord;

    assign wdExpired   = (wdCount_q == WD_LIMIT);
    assign settleDone  = (settleCnt_q == SETTLE_LAST);
    assign captureDone = (index_q == LAST_INDEX);
    assign recoverDone = (recoverCnt_q == RECOVER_LAST);

    always_comb begin
        case (index_q)
            3'd0:    selWord = i_Data0;
            3'd1:    selWord = i_Data1;
            3'd2:    selWord = i_Data2;
            3'd3:    selWord = i_Data3;
            3'd4:    selWord = i_Data4;
            default: selWord = i_Data5;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new flag edge wins over a watchdog expiry that lands in the same IDLE cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (frameRise) begin
                    state_d = SETTLE;
                end else if (wdExpired) begin
                    state_d = RECOVER;
                end
            end
            SETTLE:  if (settleDone) state_d = CAPTURE;
            CAPTURE: if (captureDone) state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            RECOVER: if (recoverDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        settleCnt_d   = '0;
        index_d       = '0;
        recoverCnt_d  = '0;
        shadow_d      = shadow_q;
        shadowFlags_d = shadowFlags_q;
        cv_d          = cv_q;
        clampFlags_d  = clampFlags_q;
        strobe_d      = 1'b0;
        linkOk_d      = linkOk_q;
        rxReset_d     = 1'b0;
        frameCount_d  = frameCount_q;
        wdCount_d     = wdExpired ? wdCount_q : wdCount_q + 24'd1;
        unique case (state_q)
            IDLE: begin
                if (!frameRise && wdExpired) begin
                    linkOk_d = 1'b0;
                end
            end
            SETTLE: settleCnt_d = settleCnt_q + 4'd1;
            CAPTURE: begin
                shadow_d[index_q]      = clampWord(selWord, CV_MAX);
                shadowFlags_d[index_q] = (selWord > CV_MAX);
                index_d                = index_q + 3'd1;
            end
            PUBLISH: begin
                cv_d         = shadow_q;
                clampFlags_d = shadowFlags_q;
                strobe_d     = 1'b1;
                frameCount_d = frameCount_q + 8'd1;
                linkOk_d     = 1'b1;
                wdCount_d    = '0;
            end
            RECOVER: begin
                wdCount_d = '0;
                linkOk_d  = 1'b0;
                if (!recoverDone) begin
                    recoverCnt_d = recoverCnt_q + 8'd1;
                    rxReset_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            settleCnt_q   <= '0;
            index_q       <= '0;
            recoverCnt_q  <= '0;
            wdCount_q     <= '0;
            shadow_q      <= '0;
            shadowFlags_q <= '0;
            cv_q          <= '0;
            clampFlags_q  <= '0;
            strobe_q      <= 1'b0;
            linkOk_q      <= 1'b0;
            rxReset_q     <= 1'b0;
            frameCount_q  <= '0;
        end else begin
            settleCnt_q   <= settleCnt_d;
            index_q       <= index_d;
            recoverCnt_q  <= recoverCnt_d;
            wdCount_q     <= wdCount_d;
            shadow_q      <= shadow_d;
            shadowFlags_q <= shadowFlags_d;
            cv_q          <= cv_d;
            clampFlags_q  <= clampFlags_d;
            strobe_q      <= strobe_d;
            linkOk_q      <= linkOk_d;
            rxReset_q     <= rxReset_d;
            frameCount_q  <= frameCount_d;
        end
    end

    assign o_CV0            = cv_q[0];
    assign o_CV1            = cv_q[1];
    assign o_CV2            = cv_q[2];
    assign o_CV3            = cv_q[3];
    assign o_CV4            = cv_q[4];
    assign o_CV5            = cv_q[5];
    assign o_Frame_Strobe   = strobe_q;
    assign o_Clamp_Flags    = clampFlags_q;
    assign o_Link_OK        = linkOk_q;
    assign o_Receiver_Reset = rxReset_q;
    assign o_Frame_Count    = frameCount_q;

endmodule

// File: tb/tb_cv_frame_controller.sv
// Bench for cv_frame_controller: directed scenarios plus random frames, all
// compared each cycle against a timeline model of when frames publish.
module tb_cv_frame_controller;

    localparam int          TIMEOUT  = 100;
    localparam int          RECOVER  = 8;
    localparam logic [15:0] CVMAX    = 16'h0FFF;

    logic        i_Clock;
    logic        i_Reset;
    logic        i_Frame_Ready;
    logic [15:0] dataDrv [6];
    logic [15:0] i_Data0, i_Data1, i_Data2, i_Data3, i_Data4, i_Data5;
    logic [15:0] o_CV0, o_CV1, o_CV2, o_CV3, o_CV4, o_CV5;
    logic        o_Frame_Strobe;
    logic [5:0]  o_Clamp_Flags;
    logic        o_Link_OK;
    logic        o_Receiver_Reset;
    logic [7:0]  o_Frame_Count;

    assign i_Data0 = dataDrv[0];
    assign i_Data1 = dataDrv[1];
    assign i_Data2 = dataDrv[2];
    assign i_Data3 = dataDrv[3];
    assign i_Data4 = dataDrv[4];
    assign i_Data5 = dataDrv[5];

    cv_frame_controller #(
        .TIMEOUT_CYCLES (24'd100)
    ) dut (
        .i_Clock          (i_Clock),
        .i_Reset          (i_Reset),
        .i_Frame_Ready    (i_Frame_Ready),
        .i_Data0          (i_Data0),
        .i_Data1          (i_Data1),
        .i_Data2          (i_Data2),
        .i_Data3          (i_Data3),
        .i_Data4          (i_Data4),
        .i_Data5          (i_Data5),
        .o_CV0            (o_CV0),
        .o_CV1            (o_CV1),
        .o_CV2            (o_CV2),
        .o_CV3            (o_CV3),
        .o_CV4            (o_CV4),
        .o_CV5            (o_CV5),
        .o_Frame_Strobe   (o_Frame_Strobe),
        .o_Clamp_Flags    (o_Clamp_Flags),
        .o_Link_OK        (o_Link_OK),
        .o_Receiver_Reset (o_Receiver_Reset),
        .o_Frame_Count    (o_Frame_Count)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    int errors = 0;
    int checks = 0;
    bit checkEnable = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Timeline model: edges are counted from reset release; a flag rise sampled at
    // edge n is seen at n+2, words are taken at n+4..n+9, the snapshot appears at n+10.
    int          edgeN;
    logic        h0, h1, h2;
    logic        mDet;
    int          freeAt, timeoutAt, capBase, pubAt, recStart;
    bit          frameActive, recActive;
    logic [15:0] mShadow [6];
    logic [5:0]  mShadowFlags;
    logic [15:0] expCV [6];
    logic [5:0]  expFlags;
    logic        expStrobe, expLink, expRx;
    logic [7:0]  expCount;

    always @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            edgeN = 0;
            h0 = 0; h1 = 0; h2 = 0;
            freeAt = 0; timeoutAt = TIMEOUT;
            frameActive = 0; recActive = 0;
            capBase = 0; pubAt = 0; recStart = 0;
            for (int k = 0; k < 6; k++) begin
                expCV[k] = '0;
                mShadow[k] = '0;
            end
            expFlags = '0; mShadowFlags = '0;
            expStrobe = 0; expLink = 0; expRx = 0; expCount = '0;
        end else begin
            edgeN++;
            mDet = h1 & ~h2;
            h2 = h1; h1 = h0; h0 = i_Frame_Ready;
            expStrobe = 0;
            if (frameActive && edgeN >= capBase && edgeN < capBase + 6) begin
                mShadow[edgeN - capBase]      = (dataDrv[edgeN - capBase] > CVMAX) ? CVMAX : dataDrv[edgeN - capBase];
                mShadowFlags[edgeN - capBase] = (dataDrv[edgeN - capBase] > CVMAX);
            end
            if (frameActive && edgeN == pubAt) begin
                for (int k = 0; k < 6; k++) expCV[k] = mShadow[k];
                expFlags    = mShadowFlags;
                expStrobe   = 1;
                expCount    = expCount + 8'd1;
                expLink     = 1;
                timeoutAt   = edgeN + TIMEOUT;
                frameActive = 0;
            end
            expRx = recActive && (edgeN >= recStart + 1) && (edgeN <= recStart + RECOVER);
            if (recActive && edgeN >= recStart + RECOVER + 1) recActive = 0;
            if (edgeN >= freeAt) begin
                if (mDet) begin
                    frameActive = 1;
                    capBase     = edgeN + 2;
                    pubAt       = edgeN + 8;
                    freeAt      = edgeN + 9;
                end else if (edgeN >= timeoutAt) begin
                    recActive = 1;
                    recStart  = edgeN;
                    expLink   = 0;
                    freeAt    = edgeN + RECOVER + 2;
                    timeoutAt = edgeN + RECOVER + 1 + TIMEOUT;
                end
            end
        end
    end

    always @(negedge i_Clock) begin
        if (!i_Reset && checkEnable) begin
            checkOutput("strobe", o_Frame_Strobe, expStrobe);
            checkOutput("linkOk", o_Link_OK, expLink);
            checkOutput("rxReset", o_Receiver_Reset, expRx);
            checkOutput("count", o_Frame_Count, expCount);
            checkOutput("flags", o_Clamp_Flags, expFlags);
            checkOutput("cv0", o_CV0, expCV[0]);
            checkOutput("cv1", o_CV1, expCV[1]);
            checkOutput("cv2", o_CV2, expCV[2]);
            checkOutput("cv3", o_CV3, expCV[3]);
            checkOutput("cv4", o_CV4, expCV[4]);
            checkOutput("cv5", o_CV5, expCV[5]);
        end
    end

    task automatic applyStimulus(input logic [5:0][15:0] words, input int highCycles, input int gapCycles);
        for (int k = 0; k < 6; k++) dataDrv[k] = words[k];
        i_Frame_Ready = 1'b1;
        repeat (highCycles) @(negedge i_Clock);
        i_Frame_Ready = 1'b0;
        repeat (gapCycles) @(negedge i_Clock);
    endtask

    function automatic logic [5:0][15:0] randomWords();
        logic [5:0][15:0] w;
        for (int k = 0; k < 6; k++) begin
            w[k] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 4095));
        end
        return w;
    endfunction

    logic [5:0][15:0] frameWords;
    logic [7:0]       savedCount;
    int               rxHigh;
    int               strobeSeen;

    initial begin
        i_Reset       = 1'b1;
        i_Frame_Ready = 1'b0;
        for (int k = 0; k < 6; k++) dataDrv[k] = '0;
        #1;
        checkOutput("rst_strobe", o_Frame_Strobe, 1'b0);
        checkOutput("rst_count", o_Frame_Count, 8'd0);
        checkOutput("rst_link", o_Link_OK, 1'b0);
        checkOutput("rst_rx", o_Receiver_Reset, 1'b0);
        checkOutput("rst_cv0", o_CV0, 16'h0);
        checkOutput("rst_flags", o_Clamp_Flags, 6'h0);
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        checkEnable = 1;
        repeat (3) @(negedge i_Clock);

        $display("[TB] single frame with clamping");
        frameWords[0] = 16'h0100; frameWords[1] = 16'h0200; frameWords[2] = 16'h0FFF;
        frameWords[3] = 16'h1000; frameWords[4] = 16'hFFFF; frameWords[5] = 16'h0000;
        applyStimulus(frameWords, 2, 9);
        checkOutput("single_strobe", o_Frame_Strobe, 1'b1);
        checkOutput("single_cv0", o_CV0, 16'h0100);
        checkOutput("single_cv1", o_CV1, 16'h0200);
        checkOutput("single_cv2", o_CV2, 16'h0FFF);
        checkOutput("single_cv3", o_CV3, 16'h0FFF);
        checkOutput("single_cv4", o_CV4, 16'h0FFF);
        checkOutput("single_cv5", o_CV5, 16'h0000);
        checkOutput("single_flags", o_Clamp_Flags, 6'b011000);
        checkOutput("single_count", o_Frame_Count, 8'd1);
        checkOutput("single_link", o_Link_OK, 1'b1);
        repeat (5) @(negedge i_Clock);

        $display("[TB] back-to-back flags");
        for (int k = 0; k < 6; k++) frameWords[k] = 16'h0ABC;
        applyStimulus(frameWords, 2, 3);
        applyStimulus(frameWords, 2, 20);
        checkOutput("b2b5_count", o_Frame_Count, 8'd2);
        applyStimulus(frameWords, 2, 10);
        applyStimulus(frameWords, 2, 20);
        checkOutput("b2b12_count", o_Frame_Count, 8'd4);

        $display("[TB] watchdog timeout");
        rxHigh = 0;
        repeat (150) begin
            @(negedge i_Clock);
            if (o_Receiver_Reset) rxHigh++;
        end
        checkOutput("timeout_rxCycles", rxHigh, RECOVER);
        checkOutput("timeout_link", o_Link_OK, 1'b0);
        checkOutput("timeout_cvHold", o_CV0, 16'h0ABC);
        frameWords = randomWords();
        applyStimulus(frameWords, 2, 12);
        checkOutput("timeout_relink", o_Link_OK, 1'b1);

        $display("[TB] reset during capture");
        frameWords = randomWords();
        applyStimulus(frameWords, 2, 4);
        i_Reset = 1'b1;
        #1;
        checkOutput("abort_strobe", o_Frame_Strobe, 1'b0);
        checkOutput("abort_count", o_Frame_Count, 8'd0);
        checkOutput("abort_link", o_Link_OK, 1'b0);
        checkOutput("abort_cv0", o_CV0, 16'h0);
        checkOutput("abort_flags", o_Clamp_Flags, 6'h0);
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b0;
        strobeSeen = 0;
        repeat (15) begin
            @(negedge i_Clock);
            if (o_Frame_Strobe) strobeSeen++;
        end
        checkOutput("abort_noStrobe", strobeSeen, 0);
        applyStimulus(frameWords, 2, 12);
        checkOutput("abort_recount", o_Frame_Count, 8'd1);

        $display("[TB] unsampled glitch");
        savedCount = expCount;
        #1 i_Frame_Ready = 1'b1;
        #2 i_Frame_Ready = 1'b0;
        repeat (20) @(negedge i_Clock);
        checkOutput("glitch_count", o_Frame_Count, savedCount);

        $display("[TB] random frames");
        for (int f = 0; f < 60; f++) begin
            frameWords = randomWords();
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(frameWords, $urandom_range(1, 3), $urandom_range(100, 130));
            end else begin
                applyStimulus(frameWords, $urandom_range(1, 3), $urandom_range(0, 14));
            end
        end
        repeat (20) @(negedge i_Clock);

        $display("[TB] counter wrap");
        savedCount = expCount;
        for (int f = 0; f < 256; f++) begin
            frameWords = randomWords();
            applyStimulus(frameWords, 2, 10);
        end
        repeat (12) @(negedge i_Clock);
        checkOutput("wrap_count", o_Frame_Count, savedCount);

        checkEnable = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
